// File: rtl/imem_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// memory geometry defaults and the occupancy helper used by the issue rule.
package imem_fetch_pkg;

    localparam int IMEM_DATA_W   = 32;
    localparam int IMEM_DEPTH    = 64;
    localparam int IMEM_RESET_PC = 0;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    // Words held in the output register, the skid entry, or still in the memory pipe.
    function automatic logic [2:0] fetch_occupancy(
        input logic out_v,
        input logic skid_v,
        input logic infl
    );
        return {2'b00, out_v} + {2'b00, skid_v} + {2'b00, infl};
    endfunction

endpackage

// File: rtl/imem_fetch_skid_buf.sv
// Two-entry order-preserving output buffer for the fetch unit: an output
// register backed by a single skid entry, with a flush that drops both.
module fetch_skid_buf
    import imem_fetch_pkg::*;
#(
    parameter int DATA_W = IMEM_DATA_W,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_pc,
    output logic              skid_valid
);

    logic [DATA_W-1:0] skid_data;
    logic [ADDR_W-1:0] skid_pc;
    logic              out_free;

    assign out_free = !out_valid || out_ready;

    // The skid entry always drains into the output register before new data,
    // so words leave in the order they arrived.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_pc     <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_pc    <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                out_pc     <= skid_pc;
                skid_valid <= in_valid;
                if (in_valid) begin
                    skid_data <= in_data;
                    skid_pc   <= in_pc;
                end
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    out_data <= in_data;
                    out_pc   <= in_pc;
                end
            end
        end else if (in_valid) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
            skid_pc    <= in_pc;
        end
    end

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch unit driving a synchronous instruction memory port.
// Define BOOT_LOAD_EN to add the boot-load stream and the LOAD state.
module imem_fetch
    import imem_fetch_pkg::*;
#(
    parameter int DATA_W   = IMEM_DATA_W,
    parameter int DEPTH    = IMEM_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int RESET_PC = IMEM_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_wre,
    output logic [DATA_W-1:0] imem_wr_data,
    input  logic [DATA_W-1:0] imem_rd_data,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
`ifdef BOOT_LOAD_EN
    ,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last
`endif
);

    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(DEPTH - 1);

`ifdef BOOT_LOAD_EN
    localparam fetch_state_e RESET_STATE = ST_LOAD;
`else
    localparam fetch_state_e RESET_STATE = ST_RUN;
`endif

    fetch_state_e      state;
    fetch_state_e      state_next;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_pc_inc;
    logic [ADDR_W-1:0] resp_pc;
    logic              inflight;
    logic              skid_valid;
    logic              accept;
    logic              flush;
    logic              issue;
    logic              resp_valid;
    logic [2:0]        occ_after;

    assign accept       = inst_valid & inst_ready;
    assign flush        = (state == ST_RUN) & redir_valid;
    assign occ_after    = fetch_occupancy(inst_valid, skid_valid, inflight) - {2'b00, accept};
    assign issue        = (state == ST_RUN) & !redir_valid & (occ_after < 3'd2);
    assign resp_valid   = inflight;
    assign fetch_pc_inc = (fetch_pc == LAST_PC) ? '0 : fetch_pc + ADDR_W'(1);

`ifdef BOOT_LOAD_EN
    logic [ADDR_W-1:0] ld_ptr;
    logic              ld_armed;
    logic              ld_accept;

    assign ld_accept = (state == ST_LOAD) & ld_armed & ld_valid;

    // ld_armed keeps ld_ready and the write strobe low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_ptr   <= '0;
            ld_armed <= 1'b0;
        end else begin
            ld_armed <= 1'b1;
            if (ld_accept) begin
                ld_ptr <= (ld_ptr == LAST_PC) ? '0 : ld_ptr + ADDR_W'(1);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
`ifdef BOOT_LOAD_EN
        if (state == ST_LOAD && ld_accept && ld_last) begin
            state_next = ST_RUN;
        end
`endif
    end

    always_comb begin
        imem_addr    = fetch_pc;
        imem_wre     = 1'b0;
        imem_wr_data = '0;
`ifdef BOOT_LOAD_EN
        ld_ready     = 1'b0;
        if (state == ST_LOAD) begin
            imem_addr    = ld_ptr;
            ld_ready     = ld_armed;
            imem_wre     = ld_valid & ld_armed;
            imem_wr_data = ld_armed ? ld_data : '0;
        end
`endif
    end

    // A redirect empties the pipe; the read issued in the redirect cycle is
    // never marked in flight, so its returning data is simply ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= START_PC;
            resp_pc  <= '0;
            inflight <= 1'b0;
        end else if (state == ST_LOAD) begin
            fetch_pc <= START_PC;
            inflight <= 1'b0;
        end else if (flush) begin
            fetch_pc <= redir_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc_inc;
                resp_pc  <= fetch_pc;
            end
        end
    end

    fetch_skid_buf #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (resp_valid),
        .in_data   (imem_rd_data),
        .in_pc     (resp_pc),
        .out_valid (inst_valid),
        .out_ready (inst_ready),
        .out_data  (inst_data),
        .out_pc    (inst_pc),
        .skid_valid(skid_valid)
    );

endmodule

// File: tb/tb_imem_fetch.sv
// Randomized self-checking bench for imem_fetch against a sequence-level model
// of the delivered instruction stream; the boot-load path runs when BOOT_LOAD_EN is defined.
`timescale 1ns/1ps
module tb_imem_fetch;
    import imem_fetch_pkg::*;

    localparam int DATA_W   = IMEM_DATA_W;
    localparam int DEPTH    = IMEM_DEPTH;
    localparam int ADDR_W   = $clog2(DEPTH);
    localparam int RESET_PC = IMEM_RESET_PC;
`ifdef BOOT_LOAD_EN
    localparam int RST_ADDR = 0;
`else
    localparam int RST_ADDR = RESET_PC;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_wre;
    logic [DATA_W-1:0] imem_wr_data;
    logic [DATA_W-1:0] imem_rd_data = '0;
    logic              redir_valid = 1'b0;
    logic [ADDR_W-1:0] redir_pc = '0;
    logic              inst_valid;
    logic              inst_ready = 1'b0;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
`ifdef BOOT_LOAD_EN
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data = '0;
    logic              ld_last = 1'b0;
`endif

    imem_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_wre    (imem_wre),
        .imem_wr_data(imem_wr_data),
        .imem_rd_data(imem_rd_data),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc)
`ifdef BOOT_LOAD_EN
        ,
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous memory with one-cycle registered read.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (imem_wre) mem[imem_addr] <= imem_wr_data;
        imem_rd_data <= mem[imem_addr];
    end

    // Reference model: expected memory contents and next expected PC in the stream.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                exp_pc;
    int                since;
    int                target_pc;
    bit                have_target;
    bit                held;
    bit                prev_ready;
    logic [ADDR_W-1:0] held_pc;
    logic [DATA_W-1:0] held_data;

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit rdy, input bit rv, input int rpc);
        inst_ready  = rdy;
        redir_valid = rv;
        redir_pc    = ADDR_W'(rpc);
`ifdef BOOT_LOAD_EN
        ld_valid = 1'b0;
        ld_last  = 1'b0;
`endif
    endtask

    // One RUN cycle: drive inputs at the falling edge, check, then advance the model.
    task automatic runCycle(input bit rdy, input bit rv, input int rpc);
        int d;
        @(negedge clk);
        applyStimulus(rdy, rv, rpc);
        #1;
        since++;
        checkOutput("run_wre", 64'(imem_wre), 64'(0));
        checkOutput("valid", 64'(inst_valid), 64'(since >= 3));
        if (since == 1 && have_target) checkOutput("target_addr", 64'(imem_addr), 64'(target_pc));
        d = (int'(imem_addr) - exp_pc + DEPTH) % DEPTH;
        checkOutput("ahead_le2", 64'(d <= 2), 64'(1));
        if (!prev_ready && since >= 4) checkOutput("buf_full", 64'(d), 64'(2));
        if (held) begin
            checkOutput("hold_pc", 64'(inst_pc), 64'(held_pc));
            checkOutput("hold_data", 64'(inst_data), 64'(held_data));
        end
        if (inst_valid && inst_ready) begin
            checkOutput("pc", 64'(inst_pc), 64'(exp_pc));
            checkOutput("data", 64'(inst_data), 64'(ref_mem[exp_pc]));
            exp_pc = (exp_pc + 1) % DEPTH;
        end
        held       = inst_valid && !inst_ready && !redir_valid;
        held_pc    = inst_pc;
        held_data  = inst_data;
        prev_ready = inst_ready;
        if (redir_valid) begin
            exp_pc      = rpc;
            target_pc   = rpc;
            have_target = 1'b1;
            since       = 0;
        end
    endtask

`ifdef BOOT_LOAD_EN
    task automatic doLoad();
        int i = 0;
        int cyc = 0;
        while (i < 4 && cyc < 20) begin
            @(negedge clk);
            redir_valid = 1'b0;
            ld_valid    = (cyc != 2);
            ld_data     = DATA_W'(32'hA0 + i);
            ld_last     = (i == 3) && (cyc != 2);
            #1;
            checkOutput("ld_ready", 64'(ld_ready), 64'(1));
            checkOutput("ld_wre", 64'(imem_wre), 64'(ld_valid));
            checkOutput("ld_inst_valid", 64'(inst_valid), 64'(0));
            if (ld_valid) begin
                checkOutput("ld_addr", 64'(imem_addr), 64'(i));
                checkOutput("ld_wdata", 64'(imem_wr_data), 64'(ld_data));
                ref_mem[i] = ld_data;
                i++;
            end
            cyc++;
        end
        checkOutput("ld_done", 64'(i), 64'(4));
        exp_pc      = RESET_PC;
        target_pc   = RESET_PC;
        have_target = 1'b1;
        since       = 0;
    endtask
`endif

    // Asserts reset away from the clock edge so the asynchronous clear is observable.
    task automatic doReset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_valid", 64'(inst_valid), 64'(0));
        checkOutput("rst_addr", 64'(imem_addr), 64'(RST_ADDR));
        checkOutput("rst_pc", 64'(inst_pc), 64'(0));
        checkOutput("rst_data", 64'(inst_data), 64'(0));
        checkOutput("rst_wre", 64'(imem_wre), 64'(0));
        checkOutput("rst_wdata", 64'(imem_wr_data), 64'(0));
`ifdef BOOT_LOAD_EN
        checkOutput("rst_ld_ready", 64'(ld_ready), 64'(0));
`endif
        repeat (2) @(negedge clk);
        rst_n       = 1'b1;
        exp_pc      = RESET_PC;
        since       = 1;
        held        = 1'b0;
        prev_ready  = 1'b1;
        have_target = 1'b0;
`ifdef BOOT_LOAD_EN
        doLoad();
`endif
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = DATA_W'(32'h1000 + i);
            ref_mem[i] = DATA_W'(32'h1000 + i);
        end
        applyStimulus(1'b1, 1'b0, 0);
        doReset();

        // Streaming with the consumer always ready.
        repeat (20) runCycle(1'b1, 1'b0, 0);
        // Five-cycle stall, then redirect while both buffer slots are full.
        repeat (5) runCycle(1'b0, 1'b0, 0);
        runCycle(1'b0, 1'b1, 'h20);
        repeat (6) runCycle(1'b1, 1'b0, 0);
        // Wrap at the top of memory.
        runCycle(1'b1, 1'b1, DEPTH - 2);
        repeat (8) runCycle(1'b1, 1'b0, 0);

        for (int n = 0; n < 400; n++) begin
            runCycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                     int'($urandom_range(0, DEPTH - 1)));
        end

        // Reset pulse during backpressure.
        repeat (4) runCycle(1'b0, 1'b0, 0);
        doReset();
        for (int n = 0; n < 60; n++) begin
            runCycle($urandom_range(0, 1) != 0, $urandom_range(0, 29) == 0,
                     int'($urandom_range(0, DEPTH - 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
